// File: rtl/galois_pkg.sv
// Shared BN254 field constants and helpers for the Griffin multiplier cluster.
// The Barrett constant is derived from the modulus at elaboration time so the two can never disagree.
package galois_pkg;

  localparam int BN_BITS         = 254;
  localparam int BARRETT_LATENCY = 12;

  localparam logic [255:0] BN254_P_HEX =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [BN_BITS-1:0] PRIME_MODULUS = BN254_P_HEX[BN_BITS-1:0];

  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // floor(2^508 / p) by restoring long division; the quotient fits in 255 bits since p > 2^253.
  function automatic logic [BN_BITS:0] barrett_r_calc(input logic [BN_BITS-1:0] p);
    logic [BN_BITS:0] rem;
    logic [BN_BITS:0] q;
    rem = '0;
    q   = '0;
    for (int i = 2*BN_BITS; i >= 0; i--) begin
      rem = {rem[BN_BITS-1:0], (i == 2*BN_BITS)};
      if (rem >= {1'b0, p}) begin
        rem = rem - {1'b0, p};
        if (i <= BN_BITS) q[i] = 1'b1;
      end
    end
    return q;
  endfunction

  localparam logic [BN_BITS:0] BARRETT_R = barrett_r_calc(PRIME_MODULUS);

endpackage

// File: rtl/galois_mult_barrett_sync.sv
// Fully pipelined Barrett modular multiplier: product = (a*b) mod p, LATENCY cycles, one op per cycle.
// Contents are never reset; the caller tracks validity alongside.
module galois_mult_barrett_sync #(
  parameter int                N_BITS        = galois_pkg::BN_BITS,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = galois_pkg::PRIME_MODULUS,
  parameter logic [N_BITS:0]   BARRETT_R     = galois_pkg::BARRETT_R,
  parameter int                LATENCY       = galois_pkg::BARRETT_LATENCY
) (
  input  logic              clk,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS-1:0] product
);

  localparam int K   = N_BITS;
  localparam int DLY = LATENCY - 3;
  localparam logic [K+1:0] P_EXT = {2'b00, PRIME_MODULUS};

  logic [2*K-1:0] x_q;
  logic [K:0]     q3_q;
  logic [K+1:0]   r1_q;
  logic [K+1:0]   r_q;
  logic [K+1:0]   r_c1;
  logic [K+1:0]   r_c2;
  logic [K-1:0]   dly_q [DLY];

  // Remainder is kept mod 2^(K+2): with a binary radix the estimate can be up to 3p, which exceeds 2^(K+1).
  always_ff @(posedge clk) begin
    x_q  <= {{K{1'b0}}, a} * {{K{1'b0}}, b};
    q3_q <= (K+1)'(({{(K+1){1'b0}}, x_q[2*K-1:K-1]} * {{(K+1){1'b0}}, BARRETT_R}) >> (K+1));
    r1_q <= x_q[K+1:0];
    r_q  <= r1_q - (K+2)'({{(K+1){1'b0}}, q3_q} * {{(K+2){1'b0}}, PRIME_MODULUS});
  end

  always_comb begin
    r_c1 = (r_q  >= P_EXT) ? r_q  - P_EXT : r_q;
    r_c2 = (r_c1 >= P_EXT) ? r_c1 - P_EXT : r_c1;
  end

  always_ff @(posedge clk) begin
    dly_q[0] <= K'(r_c2);
    for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
  end

  assign product = dly_q[DLY-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant over req starting at rr_ptr; pointer moves past the winner on advance.
module rr_arbiter
  import galois_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  input  logic         advance
);

  localparam int PW = tag_w(N);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] next_ptr;

  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_idx    = idx;
      end
    end
  end

  assign next_ptr = (win_idx == PW'(N-1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset)        rr_ptr <= '0;
    else if (advance) rr_ptr <= next_ptr;
  end

endmodule

// File: rtl/galois_mult_arbiter.sv
// Shares one pipelined modular multiplier among N_REQ requesters; a tag pipe matched to the
// multiplier latency routes each product back to its issuer, in issue order.
module galois_mult_arbiter #(
  parameter int                N_BITS        = galois_pkg::BN_BITS,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = galois_pkg::PRIME_MODULUS,
  parameter logic [N_BITS:0]   BARRETT_R     = galois_pkg::BARRETT_R,
  parameter int                N_REQ         = 4,
  parameter int                MULT_LATENCY  = galois_pkg::BARRETT_LATENCY
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0][N_BITS-1:0]       req_a,
  input  logic [N_REQ-1:0][N_BITS-1:0]       req_b,
  output logic [N_REQ-1:0]                   resp_valid,
  output logic [N_BITS-1:0]                  resp_data,
  output logic [$clog2(MULT_LATENCY+3)-1:0]  in_flight,
  output logic                               busy
);

  localparam int TW = galois_pkg::tag_w(N_REQ);

  logic [N_REQ-1:0]  grant;
  logic              transfer;
  logic [TW-1:0]     grant_idx;
  logic              issue_vld;
  logic [TW-1:0]     issue_tag;
  logic [N_BITS-1:0] op_a;
  logic [N_BITS-1:0] op_b;
  logic [N_BITS-1:0] product;
  logic [MULT_LATENCY-1:0] vld_pipe;
  logic [TW-1:0]     tag_pipe [MULT_LATENCY];
  logic              resp_any;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .grant   (grant),
    .advance (transfer)
  );

  // Grants are suppressed while reset is held so nothing is accepted during that cycle.
  assign req_ready = reset ? '0 : grant;
  assign transfer  = |(req_valid & req_ready);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) grant_idx = TW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_vld <= 1'b0;
    end else begin
      issue_vld <= transfer;
      if (transfer) begin
        op_a      <= req_a[grant_idx];
        op_b      <= req_b[grant_idx];
        issue_tag <= grant_idx;
      end
    end
  end

  galois_mult_barrett_sync #(
    .N_BITS        (N_BITS),
    .PRIME_MODULUS (PRIME_MODULUS),
    .BARRETT_R     (BARRETT_R),
    .LATENCY       (MULT_LATENCY)
  ) u_mult (
    .clk     (clk),
    .a       (op_a),
    .b       (op_b),
    .product (product)
  );

  // Only the valid bits are reset; stale tags and products are masked by them.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[MULT_LATENCY-2:0], issue_vld};
  end

  always_ff @(posedge clk) begin
    tag_pipe[0] <= issue_tag;
    for (int i = 1; i < MULT_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (vld_pipe[MULT_LATENCY-1]) begin
      resp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << tag_pipe[MULT_LATENCY-1];
      resp_data  <= product;
    end else begin
      resp_valid <= '0;
    end
  end

  assign resp_any = |resp_valid;

  always_ff @(posedge clk) begin
    if (reset)                      in_flight <= '0;
    else if (transfer && !resp_any) in_flight <= in_flight + 1'b1;
    else if (!transfer && resp_any) in_flight <= in_flight - 1'b1;
  end

  assign busy = (in_flight != '0);

endmodule

// File: tb/tb_galois_mult_arbiter.sv
// Directed bench for galois_mult_arbiter: stimulus pushes expected responses into a scoreboard,
// a negedge monitor pops and compares strobe, data and arrival cycle.
module tb_galois_mult_arbiter;

  localparam int NB  = 254;
  localparam int NR  = 4;
  localparam int LAT = 12;
  localparam int CW  = $clog2(LAT+3);
  localparam logic [255:0] P_HEX =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NR-1:0]           req_valid;
  logic [NR-1:0]           req_ready;
  logic [NR-1:0][NB-1:0]   req_a;
  logic [NR-1:0][NB-1:0]   req_b;
  logic [NR-1:0]           resp_valid;
  logic [NB-1:0]           resp_data;
  logic [CW-1:0]           in_flight;
  logic                    busy;

  logic [NB-1:0] p_m1;
  logic [NB-1:0] p_m2;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  logic started = 1'b0;

  typedef struct {
    logic [NR-1:0] strobe;
    logic [NB-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  galois_mult_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .in_flight  (in_flight),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (started && resp_valid != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: actual strobe=%b data=%0h required no response (cycle %0d)",
                 resp_valid, resp_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_strobe", 256'(resp_valid), 256'(e.strobe));
        check("resp_data",   256'(resp_data),  256'(e.data));
        check("resp_cycle",  256'(cyc),        256'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string name, input logic [NR-1:0] g, input logic [NB-1:0] prod);
    @(negedge clk);
    check(name, 256'(req_ready), 256'(g));
    if (g != '0) sb.push_back('{g, prod, cyc + LAT + 2});
  endtask

  task automatic drain();
    int n;
    n = 0;
    tick();
    while ((sb.size() != 0 || in_flight != '0) && n < 60) begin
      tick();
      n++;
    end
    check("drain_queue_empty", 256'(sb.size()), 256'(0));
    check("drain_in_flight", 256'(in_flight), 256'(0));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int cnt0;
    int cnt2;
    reset     = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    p_m1      = P_HEX[NB-1:0] - 1'b1;
    p_m2      = P_HEX[NB-1:0] - 2'd2;

    // Reset state: no grant even with all valid, registered outputs cleared.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 256'(req_ready), 256'(0));
    req_valid = '0;
    tick();
    reset   = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check("rst_resp_valid", 256'(resp_valid), 256'(0));
    check("rst_resp_data",  256'(resp_data),  256'(0));
    check("rst_in_flight",  256'(in_flight),  256'(0));
    check("rst_busy",       256'(busy),       256'(0));

    // Single request: 2*3 on requester 1.
    tick();
    req_valid = 4'b0010;
    req_a[1]  = 2;
    req_b[1]  = 3;
    expect_grant("t1_grant", 4'b0010, 6);
    check("t1_in_flight_T", 256'(in_flight), 256'(0));
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) req_valid = '0;
      @(negedge clk);
      check("t1_in_flight", 256'(in_flight), (k <= 14) ? 256'(1) : 256'(0));
    end
    drain();

    // Field boundaries: (p-1)^2 = 1 and (p-1)*2 = p-2.
    tick();
    req_valid = 4'b0001;
    req_a[0]  = p_m1;
    req_b[0]  = p_m1;
    expect_grant("t2_grant0", 4'b0001, 1);
    tick();
    req_valid = 4'b0100;
    req_a[2]  = p_m1;
    req_b[2]  = 2;
    expect_grant("t2_grant2", 4'b0100, p_m2);
    tick();
    req_valid = '0;
    drain();

    // All four contend from rr_ptr=0: grants 0,1,2,3.
    pulse_reset();
    req_valid = '1;
    for (int i = 0; i < NR; i++) begin
      req_a[i] = NB'(i + 2);
      req_b[i] = NB'(i + 5);
    end
    for (int k = 0; k < NR; k++) begin
      logic [NR-1:0] g;
      if (k > 0) begin
        tick();
        req_valid[k-1] = 1'b0;
      end
      g = 4'b0001 << k;
      expect_grant("t3_grant", g, NB'((k + 2) * (k + 5)));
    end
    tick();
    req_valid[3] = 1'b0;
    @(negedge clk);
    check("t3_in_flight_peak", 256'(in_flight), 256'(4));
    drain();

    // Requesters 0 and 2 both streaming: strict alternation, gap-free responses.
    tick();
    cnt0 = 0;
    cnt2 = 0;
    req_valid = 4'b0101;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      req_a[0] = NB'(cnt0 + 1);
      req_b[0] = 3;
      req_a[2] = NB'(cnt2 + 1);
      req_b[2] = 7;
      if (c % 2 == 0) begin
        expect_grant("t4_grant", 4'b0001, NB'(3 * (cnt0 + 1)));
        cnt0++;
      end else begin
        expect_grant("t4_grant", 4'b0100, NB'(7 * (cnt2 + 1)));
        cnt2++;
      end
    end
    tick();
    req_valid = '0;
    drain();

    // Reset mid-flight: five issues discarded, pointer back to 0.
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      req_valid = 4'b0010;
      req_a[1]  = NB'(k + 1);
      req_b[1]  = 1;
      @(negedge clk);
      check("t5_grant", 256'(req_ready), 256'(4'b0010));
    end
    tick();
    req_valid = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_in_flight", 256'(in_flight),  256'(0));
    check("t5_busy",      256'(busy),       256'(0));
    check("t5_resp_valid",256'(resp_valid), 256'(0));
    check("t5_resp_data", 256'(resp_data),  256'(0));
    repeat (5) tick();
    req_valid = '1;
    req_a[0]  = 11;
    req_b[0]  = 13;
    for (int i = 1; i < NR; i++) begin
      req_a[i] = 1;
      req_b[i] = 1;
    end
    expect_grant("t5_ptr_after_reset", 4'b0001, 143);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t5_in_flight_new", 256'(in_flight), 256'(1));
    drain();

    // Requester 3 streams i*(i+1): pipeline fills to its maximum occupancy.
    tick();
    t0 = cyc;
    req_valid = 4'b1000;
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) tick();
      req_a[3] = NB'(i);
      req_b[3] = NB'(i + 1);
      expect_grant("t6_grant", 4'b1000, NB'(i * (i + 1)));
      if (cyc - t0 >= 1) check("t6_busy", 256'(busy), 256'(1));
      if (cyc - t0 == 14 || cyc - t0 == 15) check("t6_in_flight_max", 256'(in_flight), 256'(14));
    end
    for (int k = 16; k <= 30; k++) begin
      tick();
      if (k == 16) req_valid = '0;
      @(negedge clk);
      check("t6_busy_tail", 256'(busy), (k <= 29) ? 256'(1) : 256'(0));
      if (k == 16) check("t6_in_flight_max", 256'(in_flight), 256'(14));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
